// File: rtl/control_pipe.sv
// ID-stage decode and ID/EX pipeline register with load-use interlock and
// multi-cycle divide hold for an RV32I(M) in-order core.
module control_pipe #(
  parameter int unsigned ALU_OP_W = 4,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned DIV_LAT  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                valid_in,
  input  logic [6:0]          opcode,
  input  logic [2:0]          fun_3,
  input  logic [6:0]          fun_7,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rd,
  input  logic                flush,
  output logic                stall,
  output logic                ex_hold,
  output logic                valid_out,
  output logic                illegal,
  output logic [4:0]          rd_out,
  output logic                d_mem_r,
  output logic                d_mem_w,
  output logic                jump,
  output logic                branch,
  output logic                wrten_reg,
  output logic                mux_complmnt,
  output logic                mux_d_mem,
  output logic                mux_inp_1,
  output logic                mux_inp_2,
  output logic [1:0]          mux_result,
  output logic [2:0]          mux_wire_module,
  output logic [ALU_OP_W-1:0] alu_op
);

  localparam int unsigned CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic                valid;
    logic                illegal;
    logic [4:0]          rd;
    logic                d_mem_r;
    logic                d_mem_w;
    logic                jump;
    logic                branch;
    logic                wrten_reg;
    logic                mux_complmnt;
    logic                mux_d_mem;
    logic                mux_inp_1;
    logic                mux_inp_2;
    logic [1:0]          mux_result;
    logic [2:0]          mux_wire_module;
    logic [ALU_OP_W-1:0] alu_op;
  } idex_t;

  typedef enum logic {IDLE = 1'b0, DIV_BUSY = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  idex_t            idex;
  idex_t            dec_c;
  logic             is_div_c;
  logic             uses_rs1_c;
  logic             uses_rs2_c;
  logic             load_use_c;

  // Instruction decode of the ID-stage fields
  always_comb begin
    dec_c       = '0;
    is_div_c    = 1'b0;
    uses_rs1_c  = 1'b1;
    uses_rs2_c  = 1'b0;
    dec_c.valid = 1'b1;
    dec_c.rd    = rd;
    unique case (opcode)
      OPC_LUI: begin
        uses_rs1_c = 1'b0;
        {dec_c.wrten_reg, dec_c.mux_d_mem} = 2'b11;
        dec_c.mux_result = 2'd1;
        dec_c.mux_wire_module = 3'd3;
      end
      OPC_AUIPC: begin
        uses_rs1_c = 1'b0;
        {dec_c.wrten_reg, dec_c.mux_d_mem, dec_c.mux_inp_2, dec_c.mux_inp_1} = 4'b1111;
        dec_c.mux_result = 2'd2;
        dec_c.mux_wire_module = 3'd3;
      end
      OPC_JAL: begin
        uses_rs1_c = 1'b0;
        dec_c.jump = 1'b1;
        {dec_c.wrten_reg, dec_c.mux_d_mem, dec_c.mux_inp_2, dec_c.mux_inp_1} = 4'b1111;
        dec_c.mux_result = 2'd3;
        dec_c.mux_wire_module = 3'd1;
      end
      OPC_JALR: begin
        dec_c.jump = 1'b1;
        {dec_c.wrten_reg, dec_c.mux_d_mem, dec_c.mux_inp_2} = 3'b111;
        dec_c.mux_result = 2'd3;
        dec_c.mux_wire_module = 3'd4;
      end
      OPC_BRANCH: begin
        uses_rs2_c = 1'b1;
        dec_c.branch = 1'b1;
        dec_c.mux_complmnt = 1'b1;
      end
      OPC_LOAD: begin
        dec_c.d_mem_r = 1'b1;
        {dec_c.wrten_reg, dec_c.mux_inp_2} = 2'b11;
        dec_c.mux_result = 2'd2;
        dec_c.mux_wire_module = 3'd4;
      end
      OPC_STORE: begin
        uses_rs2_c = 1'b1;
        dec_c.d_mem_w = 1'b1;
        dec_c.mux_inp_2 = 1'b1;
        dec_c.mux_result = 2'd2;
        dec_c.mux_wire_module = 3'd2;
      end
      OPC_OPIMM: begin
        {dec_c.wrten_reg, dec_c.mux_d_mem, dec_c.mux_inp_2} = 3'b111;
        dec_c.mux_result = 2'd2;
        dec_c.mux_wire_module = 3'd4;
        dec_c.alu_op = ALU_OP_W'(fun_3);
        dec_c.mux_complmnt = (fun_3 == 3'b101) & fun_7[5];
      end
      OPC_OP: begin
        uses_rs2_c = 1'b1;
        {dec_c.wrten_reg, dec_c.mux_d_mem} = 2'b11;
        dec_c.mux_result = 2'd2;
        if (fun_7 == 7'b0000000 || fun_7 == 7'b0100000) begin
          dec_c.alu_op = ALU_OP_W'(fun_3);
          dec_c.mux_complmnt = fun_7[5];
        end else if (fun_7 == 7'b0000001 && ENABLE_M) begin
          dec_c.alu_op = ALU_OP_W'({1'b1, fun_3});
          is_div_c = fun_3[2];
        end else begin
          dec_c.illegal = 1'b1;
        end
      end
      default: dec_c.illegal = 1'b1;
    endcase
    // Illegal instructions travel as a valid bundle with every control cleared
    if (dec_c.illegal) begin
      dec_c         = '0;
      dec_c.valid   = 1'b1;
      dec_c.illegal = 1'b1;
      dec_c.rd      = rd;
      is_div_c      = 1'b0;
    end
    if (!valid_in) begin
      dec_c    = '0;
      is_div_c = 1'b0;
    end
  end

  always_comb begin
    load_use_c = idex.valid & idex.d_mem_r & (idex.rd != 5'd0) & valid_in &
                 ((uses_rs1_c & (idex.rd == rs1)) | (uses_rs2_c & (idex.rd == rs2)));
    stall = ~flush & ((state == DIV_BUSY) | load_use_c);
  end

  // ID/EX register and divide sequencer; ex_hold follows a divide resident in EX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idex    <= '0;
      ex_hold <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      cnt     <= '0;
      idex    <= '0;
      ex_hold <= 1'b0;
    end else if (state == DIV_BUSY) begin
      if (cnt == CNT_W'(1)) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else if (load_use_c) begin
      idex    <= '0;
      ex_hold <= 1'b0;
    end else begin
      idex    <= dec_c;
      ex_hold <= is_div_c;
      if (is_div_c) begin
        state <= DIV_BUSY;
        cnt   <= CNT_W'(DIV_LAT - 1);
      end
    end
  end

  assign valid_out       = idex.valid;
  assign illegal         = idex.illegal;
  assign rd_out          = idex.rd;
  assign d_mem_r         = idex.d_mem_r;
  assign d_mem_w         = idex.d_mem_w;
  assign jump            = idex.jump;
  assign branch          = idex.branch;
  assign wrten_reg       = idex.wrten_reg;
  assign mux_complmnt    = idex.mux_complmnt;
  assign mux_d_mem       = idex.mux_d_mem;
  assign mux_inp_1       = idex.mux_inp_1;
  assign mux_inp_2       = idex.mux_inp_2;
  assign mux_result      = idex.mux_result;
  assign mux_wire_module = idex.mux_wire_module;
  assign alu_op          = idex.alu_op;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: reference model per instance (M enabled / disabled)
// checked every cycle, plus directed literal expectations.
module tb_control_pipe;

  localparam int unsigned DLAT = 8;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef struct packed {
    logic v; logic ill; logic [4:0] rd;
    logic dr; logic dw; logic j; logic b; logic wr; logic cm; logic dm; logic i1; logic i2;
    logic [1:0] res; logic [2:0] wm; logic [3:0] alu;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b1, valid_in = 1'b0, flush = 1'b0;
  logic [6:0] opcode = '0, fun_7 = '0;
  logic [2:0] fun_3 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic stall, ex_hold, valid_out, illegal, d_mem_r, d_mem_w, jump, branch, wrten_reg;
  logic mux_complmnt, mux_d_mem, mux_inp_1, mux_inp_2;
  logic [1:0] mux_result; logic [2:0] mux_wire_module; logic [3:0] alu_op; logic [4:0] rd_out;

  logic n_stall, n_ex_hold, n_valid_out, n_illegal, n_d_mem_r, n_d_mem_w, n_jump, n_branch, n_wrten_reg;
  logic n_mux_complmnt, n_mux_d_mem, n_mux_inp_1, n_mux_inp_2;
  logic [1:0] n_mux_result; logic [2:0] n_mux_wire_module; logic [3:0] n_alu_op; logic [4:0] n_rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  control_pipe #(.ALU_OP_W(4), .ENABLE_M(1'b1), .DIV_LAT(DLAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode), .fun_3(fun_3),
    .fun_7(fun_7), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush), .stall(stall),
    .ex_hold(ex_hold), .valid_out(valid_out), .illegal(illegal), .rd_out(rd_out),
    .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .jump(jump), .branch(branch), .wrten_reg(wrten_reg),
    .mux_complmnt(mux_complmnt), .mux_d_mem(mux_d_mem), .mux_inp_1(mux_inp_1),
    .mux_inp_2(mux_inp_2), .mux_result(mux_result), .mux_wire_module(mux_wire_module),
    .alu_op(alu_op));

  control_pipe #(.ALU_OP_W(4), .ENABLE_M(1'b0), .DIV_LAT(DLAT)) u_nom (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode(opcode), .fun_3(fun_3),
    .fun_7(fun_7), .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush), .stall(n_stall),
    .ex_hold(n_ex_hold), .valid_out(n_valid_out), .illegal(n_illegal), .rd_out(n_rd_out),
    .d_mem_r(n_d_mem_r), .d_mem_w(n_d_mem_w), .jump(n_jump), .branch(n_branch),
    .wrten_reg(n_wrten_reg), .mux_complmnt(n_mux_complmnt), .mux_d_mem(n_mux_d_mem),
    .mux_inp_1(n_mux_inp_1), .mux_inp_2(n_mux_inp_2), .mux_result(n_mux_result),
    .mux_wire_module(n_mux_wire_module), .alu_op(n_alu_op));

  exp_t act0, act1;
  assign act0 = {valid_out, illegal, rd_out, d_mem_r, d_mem_w, jump, branch, wrten_reg,
                 mux_complmnt, mux_d_mem, mux_inp_1, mux_inp_2, mux_result, mux_wire_module, alu_op};
  assign act1 = {n_valid_out, n_illegal, n_rd_out, n_d_mem_r, n_d_mem_w, n_jump, n_branch,
                 n_wrten_reg, n_mux_complmnt, n_mux_d_mem, n_mux_inp_1, n_mux_inp_2,
                 n_mux_result, n_mux_wire_module, n_alu_op};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table
  function automatic exp_t tab(exp_t e, bit wr, bit dm, logic [1:0] res, bit i2, bit i1,
                               logic [2:0] wm);
    exp_t r;
    r = e; r.wr = wr; r.dm = dm; r.res = res; r.i2 = i2; r.i1 = i1; r.wm = wm;
    return r;
  endfunction

  function automatic exp_t ref_decode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                      logic [4:0] rdi, bit en_m);
    exp_t e;
    e = '0; e.v = 1'b1; e.rd = rdi;
    case (op)
      LUI:    e = tab(e, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 3'd3);
      AUIPC:  e = tab(e, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 3'd3);
      JAL:    begin e = tab(e, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 3'd1); e.j = 1'b1; end
      JALR:   begin e = tab(e, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 3'd4); e.j = 1'b1; end
      BRANCH: begin e.b = 1'b1; e.cm = 1'b1; end
      LOAD:   begin e = tab(e, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 3'd4); e.dr = 1'b1; end
      STORE:  begin e = tab(e, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 3'd2); e.dw = 1'b1; end
      OPIMM:  begin
        e = tab(e, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 3'd4);
        e.alu = {1'b0, f3};
        e.cm = (f3 == 3'b101) && f7[5];
      end
      OP: begin
        e = tab(e, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0);
        if (f7 == 7'h00 || f7 == 7'h20) begin e.alu = {1'b0, f3}; e.cm = f7[5]; end
        else if (f7 == 7'h01 && en_m) e.alu = {1'b1, f3};
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e = '0; e.v = 1'b1; e.ill = 1'b1; e.rd = rdi; end
    return e;
  endfunction

  function automatic bit is_div(exp_t e);
    return e.v && !e.ill && e.alu[3] && e.alu[2];
  endfunction

  // Model state: EX bundle, edges left frozen behind a divide, divide resident in EX
  exp_t m_reg [2];
  int   m_rem [2];
  bit   m_div [2];

  function automatic bit m_lu(int i);
    bit u1, u2;
    u1 = !(opcode == LUI || opcode == AUIPC || opcode == JAL);
    u2 = (opcode == OP || opcode == STORE || opcode == BRANCH);
    return valid_in && m_reg[i].v && m_reg[i].dr && (m_reg[i].rd != 5'd0) &&
           ((u1 && m_reg[i].rd == rs1) || (u2 && m_reg[i].rd == rs2));
  endfunction

  function automatic bit m_stall(int i);
    if (flush) return 1'b0;
    return (m_rem[i] > 0) || m_lu(i);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_reg[i] <= '0; m_rem[i] <= 0; m_div[i] <= 1'b0;
      end else if (flush) begin
        m_reg[i] <= '0; m_rem[i] <= 0; m_div[i] <= 1'b0;
      end else if (m_rem[i] > 0) begin
        m_rem[i] <= m_rem[i] - 1;
      end else if (m_lu(i) || !valid_in) begin
        m_reg[i] <= '0; m_div[i] <= 1'b0;
      end else begin
        m_reg[i] <= ref_decode(opcode, fun_3, fun_7, rd, i == 0);
        m_div[i] <= is_div(ref_decode(opcode, fun_3, fun_7, rd, i == 0));
        m_rem[i] <= is_div(ref_decode(opcode, fun_3, fun_7, rd, i == 0)) ? int'(DLAT) - 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    check("bundle_m",  32'(act0),      32'(m_reg[0]));
    check("exhold_m",  32'(ex_hold),   32'(m_div[0]));
    check("stall_m",   32'(stall),     32'(m_stall(0)));
    check("bundle_nm", 32'(act1),      32'(m_reg[1]));
    check("exhold_nm", 32'(n_ex_hold), 32'(m_div[1]));
    check("stall_nm",  32'(n_stall),   32'(m_stall(1)));
  end

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    valid_in = 1'b1; opcode = op; fun_3 = f3; fun_7 = f7; rs1 = a; rs2 = b; rd = d;
  endtask

  // Present an instruction and hold it until the edge that accepts it
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    bit s; int n;
    set_in(op, f3, f7, a, b, d);
    n = 0;
    do begin
      @(negedge clk); s = m_stall(0);
      @(posedge clk); #1; n++;
    end while (s && n < 64);
    if (s) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: still stalled after %0d cycles, expected accept", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("rst_bundle", 32'(act0), 32'd0);
    check("rst_exhold", 32'(ex_hold), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    issue(AUIPC, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3);
    check("auipc_res", 32'(mux_result), 32'd2);
    check("auipc_in1", 32'(mux_inp_1), 32'd1);
    check("auipc_wm", 32'(mux_wire_module), 32'd3);
    issue(OPIMM, 3'b101, 7'h20, 5'd1, 5'd0, 5'd4);
    check("srai_cm", 32'(mux_complmnt), 32'd1);
    check("srai_alu", 32'(alu_op), 32'd5);
    issue(OPIMM, 3'b000, 7'h20, 5'd1, 5'd0, 5'd4);
    check("addi_cm", 32'(mux_complmnt), 32'd0);
    issue(OP, 3'b000, 7'h20, 5'd1, 5'd2, 5'd5);
    issue(LUI, 3'b000, 7'h00, 5'd0, 5'd0, 5'd8);
    issue(JAL, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1);
    check("jal_jump", 32'(jump), 32'd1);
    check("jal_wm", 32'(mux_wire_module), 32'd1);
    issue(JALR, 3'b000, 7'h00, 5'd3, 5'd0, 5'd1);
    issue(BRANCH, 3'b001, 7'h00, 5'd1, 5'd2, 5'd0);
    check("br_flags", 32'({branch, mux_complmnt, wrten_reg}), 32'b110);
    issue(STORE, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0);

    issue(LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd5);
    check("lw_dr", 32'({d_mem_r, mux_d_mem}), 32'b10);
    set_in(OP, 3'b000, 7'h00, 5'd5, 5'd1, 5'd6);
    #1 check("lu_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("lu_bubble", 32'(act0), 32'd0);
    check("lu_released", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("add_after_lu", 32'({valid_out, wrten_reg, alu_op, rd_out}), 32'({1'b1, 1'b1, 4'd0, 5'd6}));

    issue(LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd7);
    issue(STORE, 3'b010, 7'h00, 5'd2, 5'd7, 5'd0);
    issue(LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd0);
    set_in(OP, 3'b000, 7'h00, 5'd0, 5'd0, 5'd9);
    #1 check("x0_nostall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    issue(LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd10);
    issue(LUI, 3'b000, 7'h00, 5'd10, 5'd10, 5'd11);

    issue(7'b1111111, 3'b000, 7'h00, 5'd1, 5'd2, 5'd12);
    check("ill_flags", 32'({valid_out, illegal}), 32'b11);
    check("ill_ctrl", 32'({wrten_reg, mux_d_mem, mux_result, mux_wire_module, alu_op}), 32'd0);
    issue(OP, 3'b000, 7'h01, 5'd1, 5'd2, 5'd13);
    check("mul_alu", 32'(alu_op), 32'b1000);
    check("mul_legal", 32'(illegal), 32'd0);
    check("nom_mul_ill", 32'({n_valid_out, n_illegal, n_wrten_reg}), 32'b110);
    issue(OP, 3'b000, 7'h02, 5'd1, 5'd2, 5'd13);

    issue(OP, 3'b100, 7'h01, 5'd1, 5'd2, 5'd14);
    set_in(OP, 3'b000, 7'h00, 5'd3, 5'd4, 5'd15);
    for (int k = 1; k <= int'(DLAT); k++) begin
      check("div_alu", 32'({valid_out, alu_op, rd_out}), 32'({1'b1, 4'b1100, 5'd14}));
      check("div_exhold", 32'(ex_hold), 32'd1);
      check("div_stall", 32'(stall), 32'(k < int'(DLAT)));
      @(posedge clk); #1;
    end
    check("div_next", 32'({valid_out, ex_hold, rd_out}), 32'({1'b1, 1'b0, 5'd15}));

    issue(OP, 3'b110, 7'h01, 5'd1, 5'd2, 5'd16);
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_bundle", 32'(act0), 32'd0);
    check("flush_exhold", 32'(ex_hold), 32'd0);
    check("flush_stall", 32'(stall), 32'd0);
    issue(OP, 3'b000, 7'h00, 5'd1, 5'd2, 5'd17);
    check("flush_idle", 32'({valid_out, rd_out}), 32'({1'b1, 5'd17}));

    issue(OP, 3'b101, 7'h01, 5'd1, 5'd2, 5'd18);
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_bundle", 32'(act0), 32'd0);
    check("rst_mid_exhold", 32'(ex_hold), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    issue(OP, 3'b000, 7'h20, 5'd1, 5'd2, 5'd19);
    check("post_rst", 32'({valid_out, mux_complmnt, wrten_reg, rd_out, ex_hold}),
          32'({1'b1, 1'b1, 1'b1, 5'd19, 1'b0}));

    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 Parameter ALU_OP_W, default 4, alu_op width; SHALL be >= 4; bit 3 selects the RV32M unit.
REQ-002 Parameter ENABLE_M, default 1, RV32M decode enabled when 1.
REQ-003 Parameter DIV_LAT, default 8, total EX cycles for DIV/DIVU/REM/REMU; SHALL be >= 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 valid_in  input  1  ID-stage instruction valid.
REQ-008 opcode  input  7  instruction[6:0].
REQ-009 fun_3  input  3  instruction[14:12].
REQ-010 fun_7  input  7  instruction[31:25].
REQ-011 rs1 / rs2 / rd  input  5 each  ID-stage register indices.
REQ-012 flush  input  1  taken branch/jump; kill the ID instruction and any EX hold.
REQ-013 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 ex_hold  output  1  registered; EX keeps its operands, divide in progress.
REQ-015 valid_out / illegal  output  1 each  ID/EX bundle valid; illegal-instruction flag.
REQ-016 rd_out  output  5  registered destination index.
REQ-017 d_mem_r, d_mem_w, jump, branch, wrten_reg, mux_complmnt, mux_d_mem, mux_inp_1, mux_inp_2  output  1 each  registered controls.
REQ-018 mux_result  output  2; mux_wire_module  output  3; alu_op  output  ALU_OP_W; all registered.

Function
REQ-019 Decode SHALL be combinational and captured into the ID/EX register on a rising edge when the register is loaded.
REQ-020 Decode table (unlisted signals 0; order is wr, d_mem, res, in2, in1, wm):
- LUI 0110111: 1,1,1,0,0,3.
- AUIPC 0010111: 1,1,2,1,1,3.
- JAL 1101111: jump=1; 1,1,3,1,1,1.
- JALR 1100111: jump=1; 1,1,3,1,0,4.
- BRANCH 1100011: branch=1, complmnt=1, all others 0.
- LOAD 0000011: d_mem_r=1; 1,0,2,1,0,4.
- STORE 0100011: d_mem_w=1; 0,0,2,1,0,2.
- OP-IMM 0010011: 1,1,2,1,0,4; alu_op=fun_3; complmnt=fun_7[5] only when fun_3=101.
- OP 0110011: 1,1,2,0,0,0; alu_op=fun_3; complmnt=fun_7[5].
REQ-021 OP with fun_7=0000001 and ENABLE_M=1 SHALL set alu_op={1,fun_3} and complmnt=0.
REQ-022 illegal=1, valid_out=1, all controls 0 for: unknown opcode; OP fun_7 not 0000000/0100000 (or 0000001 with M); M op when ENABLE_M=0.
REQ-023 Load-use hazard: registered valid_out & d_mem_r, rd_out!=0, and valid_in with rd_out==rs1 (all opcodes except LUI/AUIPC/JAL) or rd_out==rs2 (OP/STORE/BRANCH) -> stall=1; next edge loads a bubble.
REQ-024 Bubble SHALL mean valid_out=0, illegal=0, all controls and rd_out 0.
REQ-025 FSM IDLE/DIV_BUSY; a valid M op with fun_3[2]=1 loaded in IDLE -> DIV_BUSY, counter=DIV_LAT-1.
REQ-026 In DIV_BUSY: ex_hold=1, stall=1, the ID/EX register is frozen, counter decrements each cycle; at counter==1 -> IDLE and the register reloads on the following edge.
REQ-027 Result: a divide occupies EX exactly DIV_LAT cycles; MUL ops and fun_3[2]=0 ops take 1 cycle.
REQ-028 Priority SHALL be: flush > DIV_BUSY hold > load-use stall > normal load.
REQ-029 flush in any state: next edge bubble, FSM -> IDLE, counter -> 0, ex_hold -> 0.
REQ-030 valid_in=0 without stall/hold SHALL load a bubble.
REQ-031 Counter width SHALL be clog2(DIV_LAT); no wrap.

Reset
REQ-032 reset_n=0 SHALL immediately force all registered outputs to 0, FSM to IDLE, counter to 0; stall follows combinationally (0).

Verification
REQ-033 LW x5 then ADD x6,x5,x1 -> stall=1 one cycle, one bubble, then ADD with wrten_reg=1, alu_op=0.
REQ-034 DIV (fun_7=0000001, fun_3=100), DIV_LAT=8 -> alu_op=1100, ex_hold=1 for 8 cycles, next instruction loads on cycle 9.
REQ-035 flush on 3rd DIV_BUSY cycle -> next edge valid_out=0, ex_hold=0, IDLE.
REQ-036 opcode 1111111 -> valid_out=1, illegal=1, controls 0; ENABLE_M=0 with MUL -> illegal=1.
REQ-037 AUIPC -> mux_result=2, mux_inp_1=1, mux_wire_module=3; SRAI fun_7=0100000 -> mux_complmnt=1.
REQ-038 reset_n asserted mid-DIV_BUSY -> all outputs 0 without a clock edge; first instruction after release decodes normally.
